// File: rtl/mpu_uart_pkg.sv
// Shared types, constants and helpers for the MPU hex UART transmitter.
package mpu_uart_pkg;

    // Transmitter FSM states. PARITY is only visited when MPU_UART_PARITY_EN is defined.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    localparam logic [7:0] ASCII_0 = 8'h30;
    localparam logic [7:0] ASCII_A = 8'h41;

    // Map a nibble to its uppercase ASCII hex character.
    function automatic logic [7:0] nibble_to_hex(input logic [3:0] nib);
        logic [7:0] wide;
        wide = {4'h0, nib};
        if (nib < 4'd10) begin
            return ASCII_0 + wide;
        end
        return ASCII_A + (wide - 8'd10);
    endfunction

endpackage

// File: rtl/mpu_hex_uart_tx_fifo.sv
// mpu_nibble_fifo: synchronous FIFO with extra-bit pointers and first-word fall-through read.
// A push while full is accepted only when a pop happens on the same edge.
module mpu_nibble_fifo #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic                       drop,
    output logic [$clog2(DEPTH):0]     count,
    output logic [$clog2(DEPTH):0]     count_next
);

    localparam int unsigned AddrW = $clog2(DEPTH);
    localparam int unsigned PtrW  = AddrW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PtrW-1:0]  wptr_q, wptr_d;
    logic [PtrW-1:0]  rptr_q, rptr_d;
    logic [PtrW-1:0]  count_q;
    logic             full_q;
    logic             push_ok;
    logic             pop_ok;

    // Accept/drop decisions and next pointer values.
    always_comb begin
        pop_ok  = pop && (count_q != '0);
        push_ok = push && (!full_q || pop_ok);
        drop    = push && full_q && !pop_ok;
        wptr_d  = wptr_q + {{AddrW{1'b0}}, push_ok};
        rptr_d  = rptr_q + {{AddrW{1'b0}}, pop_ok};
        count_next = wptr_d - rptr_d;
    end

    // Pointers and registered occupancy flags.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_next;
            full_q  <= (count_next == PtrW'(DEPTH));
        end
    end

    // Storage needs no reset; stale entries are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr_q[AddrW-1:0]] <= wdata;
        end
    end

    assign rdata = mem[rptr_q[AddrW-1:0]];
    assign full  = full_q;
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/mpu_hex_uart_tx.sv
// mpu_hex_uart_tx: buffers MPU output-register writes and sends each as an ASCII hex
// character in a UART frame. Define MPU_UART_PARITY_EN to add an even-parity bit (8E1).
module mpu_hex_uart_tx
    import mpu_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [3:0]                    o_reg,
    input  logic                          o_reg_we,
    output logic                          tx,
    output logic                          busy,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] BaudLast = CntW'(CLKS_PER_BIT - 1);

    uart_state_t                 state_q;
    logic [CntW-1:0]             baud_q;
    logic [2:0]                  bit_q;
    logic [7:0]                  shreg_q;
    logic                        tx_q;
    logic                        busy_q;
    logic                        overflow_q;
`ifdef MPU_UART_PARITY_EN
    logic                        parity_q;
`endif

    logic                        fifo_pop;
    logic [3:0]                  fifo_rdata;
    logic                        fifo_empty;
    logic                        fifo_drop;
    logic [$clog2(FIFO_DEPTH):0] fifo_count_next;
    logic [7:0]                  hex_byte;
    logic                        baud_end;
    logic                        idle_next;
    logic                        busy_d;

    mpu_nibble_fifo #(
        .WIDTH (4),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (o_reg_we),
        .wdata      (o_reg),
        .pop        (fifo_pop),
        .rdata      (fifo_rdata),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .drop       (fifo_drop),
        .count      (fifo_count),
        .count_next (fifo_count_next)
    );

    // Pop decision, byte encoding and next-cycle busy, all from current registered state.
    always_comb begin
        fifo_pop  = (state_q == IDLE) && !fifo_empty;
        hex_byte  = nibble_to_hex(fifo_rdata);
        baud_end  = (baud_q == BaudLast);
        idle_next = ((state_q == IDLE) && fifo_empty) || ((state_q == STOP) && baud_end);
        busy_d    = !idle_next || (fifo_count_next != '0);
    end

    // Transmit FSM with baud counter, bit counter, shift register and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shreg_q    <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
`ifdef MPU_UART_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            busy_q <= busy_d;
            if (fifo_drop) begin
                overflow_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    // Same edge as the FIFO pop; the start bit begins immediately.
                    if (!fifo_empty) begin
                        shreg_q  <= hex_byte;
`ifdef MPU_UART_PARITY_EN
                        parity_q <= ^hex_byte;
`endif
                        tx_q     <= 1'b0;
                        baud_q   <= '0;
                        state_q  <= START;
                    end
                end
                START: begin
                    if (baud_end) begin
                        baud_q  <= '0;
                        bit_q   <= '0;
                        tx_q    <= shreg_q[0];
                        shreg_q <= shreg_q >> 1;
                        state_q <= DATA;
                    end else begin
                        baud_q <= baud_q + CntW'(1);
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud_q <= '0;
                        if (bit_q == 3'd7) begin
`ifdef MPU_UART_PARITY_EN
                            tx_q    <= parity_q;
                            state_q <= PARITY;
`else
                            tx_q    <= 1'b1;
                            state_q <= STOP;
`endif
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            tx_q    <= shreg_q[0];
                            shreg_q <= shreg_q >> 1;
                        end
                    end else begin
                        baud_q <= baud_q + CntW'(1);
                    end
                end
`ifdef MPU_UART_PARITY_EN
                PARITY: begin
                    if (baud_end) begin
                        baud_q  <= '0;
                        tx_q    <= 1'b1;
                        state_q <= STOP;
                    end else begin
                        baud_q <= baud_q + CntW'(1);
                    end
                end
`endif
                STOP: begin
                    if (baud_end) begin
                        baud_q  <= '0;
                        state_q <= IDLE;
                    end else begin
                        baud_q <= baud_q + CntW'(1);
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    baud_q  <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign tx       = tx_q;
    assign busy     = busy_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_mpu_hex_uart_tx.sv
// Scoreboard bench for mpu_hex_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4).
module tb_mpu_hex_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef MPU_UART_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int FRAME = FB * CPB;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] o_reg = 4'h0;
    logic       o_reg_we = 1'b0;
    logic       tx;
    logic       busy;
    logic       fifo_full;
    logic [2:0] fifo_count;
    logic       overflow;

    mpu_hex_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .o_reg      (o_reg),
        .o_reg_we   (o_reg_we),
        .tx         (tx),
        .busy       (busy),
        .fifo_full  (fifo_full),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [8:0] exp_q[$];   // {parity, byte}
    int         starts[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_byte(input logic [7:0] b, input logic p);
        exp_q.push_back({p, b});
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wr(input logic [3:0] v);
        o_reg    = v;
        o_reg_we = 1'b1;
        @(negedge clk);
        o_reg_we = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        exp_q.delete();
        starts.delete();
    endtask

    task automatic drain();
        int c = 0;
        while ((exp_q.size() != 0 || busy !== 1'b0) && c < 2000) begin
            @(negedge clk);
            c++;
        end
        chk("drain_busy", {31'd0, busy}, 0);
        chk("drain_pending", exp_q.size(), 0);
    endtask

    // Monitor: decode one frame from the first low sample, aborting if reset intervenes.
    task automatic decode_frame();
        int         pos = 0;
        logic [7:0] data = 8'h00;
        logic       par = 1'b0;
        logic       stop_b = 1'b0;
        logic       ok = 1'b1;
        logic [8:0] e;
        starts.push_back(cyc);
        for (int b = 0; b < FB && ok; b++) begin
            int target;
            target = b * CPB + CPB / 2;
            while (pos < target && ok) begin
                @(negedge clk);
                pos++;
                if (reset_n !== 1'b1) ok = 1'b0;
            end
            if (ok) begin
                if (b == 0) chk("start_bit", {31'd0, tx}, 0);
                else if (b <= 8) data[b-1] = tx;
                else if (b == FB - 1) stop_b = tx;
                else par = tx;
            end
        end
        if (ok) begin
            chk("stop_bit", {31'd0, stop_b}, 1);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_frame: got 0x%0h, want no frame (cycle %0d)", data, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("frame_byte", {24'd0, data}, {24'd0, e[7:0]});
`ifdef MPU_UART_PARITY_EN
                chk("parity_bit", {31'd0, par}, {31'd0, e[8]});
`endif
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (reset_n === 1'b1 && tx === 1'b0) decode_frame();
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pk;
        int low;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_tx", {31'd0, tx}, 1);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_full", {31'd0, fifo_full}, 0);
        chk("rst_count", {29'd0, fifo_count}, 0);
        chk("rst_overflow", {31'd0, overflow}, 0);
        reset_n = 1'b1;
        repeat (5) tick();

        // Single write of 0xA -> 0x41
        expect_byte(8'h41, 1'b0);
        wr(4'hA);
        chk("single_count_after_push", {29'd0, fifo_count}, 1);
        chk("single_busy_rise", {31'd0, busy}, 1);
        chk("single_tx_idle", {31'd0, tx}, 1);
        tick();
        chk("single_tx_fall", {31'd0, tx}, 0);
        chk("single_count_after_pop", {29'd0, fifo_count}, 0);
        repeat (FRAME - 1) tick();
        chk("single_busy_last", {31'd0, busy}, 1);
        tick();
        chk("single_busy_fall", {31'd0, busy}, 0);
        drain();

        // Burst 0x3, 0x9, 0xF
        do_reset();
        expect_byte(8'h33, 1'b0);
        expect_byte(8'h39, 1'b0);
        expect_byte(8'h46, 1'b1);
        pk = 0;
        wr(4'h3); if (int'(fifo_count) > pk) pk = int'(fifo_count);
        wr(4'h9); if (int'(fifo_count) > pk) pk = int'(fifo_count);
        wr(4'hF); if (int'(fifo_count) > pk) pk = int'(fifo_count);
        repeat (3) begin
            tick();
            if (int'(fifo_count) > pk) pk = int'(fifo_count);
        end
        chk("burst_peak", pk, 2);
        drain();
        chk("burst_frames", starts.size(), 3);
        if (starts.size() == 3) begin
            chk("burst_gap1", starts[1] - starts[0], FRAME + 1);
            chk("burst_gap2", starts[2] - starts[1], FRAME + 1);
        end

        // Overflow: 0x0..0x5, last one dropped
        do_reset();
        for (int i = 0; i < 5; i++) expect_byte(8'h30 + 8'(i), (i == 1 || i == 2 || i == 4));
        wr(4'h0);
        wr(4'h1);
        chk("ovf_first_pop_tx", {31'd0, tx}, 0);
        chk("ovf_count_w2", {29'd0, fifo_count}, 1);
        wr(4'h2);
        wr(4'h3);
        wr(4'h4);
        chk("ovf_full", {31'd0, fifo_full}, 1);
        chk("ovf_count_w5", {29'd0, fifo_count}, 4);
        chk("ovf_not_yet", {31'd0, overflow}, 0);
        wr(4'h5);
        chk("ovf_count_w6", {29'd0, fifo_count}, 4);
        chk("ovf_set", {31'd0, overflow}, 1);
        drain();
        chk("ovf_sticky", {31'd0, overflow}, 1);

        // Full FIFO with a write on the pop edge
        do_reset();
        expect_byte(8'h42, 1'b0);
        expect_byte(8'h43, 1'b1);
        expect_byte(8'h44, 1'b0);
        expect_byte(8'h45, 1'b1);
        expect_byte(8'h31, 1'b1);
        expect_byte(8'h32, 1'b1);
        chk("sim_ovf_cleared", {31'd0, overflow}, 0);
        wr(4'hB);
        wr(4'hC);
        wr(4'hD);
        wr(4'hE);
        wr(4'h1);
        chk("sim_full", {31'd0, fifo_full}, 1);
        chk("sim_count_full", {29'd0, fifo_count}, 4);
        repeat (FRAME - 3) tick();
        chk("sim_idle_gap_tx", {31'd0, tx}, 1);
        wr(4'h2);
        chk("sim_count_kept", {29'd0, fifo_count}, 4);
        chk("sim_still_full", {31'd0, fifo_full}, 1);
        chk("sim_no_overflow", {31'd0, overflow}, 0);
        chk("sim_next_start", {31'd0, tx}, 0);
        drain();

        // Reset during DATA bit 3 of 0x7 (second entry queued behind it)
        do_reset();
        wr(4'h7);
        wr(4'h8);
        repeat (16) tick();
        chk("midrst_tx_bit3", {31'd0, tx}, 0);
        reset_n = 1'b0;
        tick();
        chk("midrst_tx", {31'd0, tx}, 1);
        chk("midrst_count", {29'd0, fifo_count}, 0);
        chk("midrst_busy", {31'd0, busy}, 0);
        tick();
        reset_n = 1'b1;
        exp_q.delete();
        starts.delete();
        low = 0;
        repeat (2 * FRAME) begin
            tick();
            if (tx !== 1'b1) low++;
        end
        chk("midrst_no_residual_low", low, 0);
        chk("midrst_no_frames", starts.size(), 0);

`ifdef MPU_UART_PARITY_EN
        // Parity build: 0x41 -> 0, 0x37 -> 1
        do_reset();
        expect_byte(8'h41, 1'b0);
        wr(4'hA);
        drain();
        expect_byte(8'h37, 1'b1);
        wr(4'h7);
        drain();
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
